// File: rtl/fc_tcdm_demux_pkg.sv
// Shared types and helpers for the fabric-controller TCDM address demux.
package fc_tcdm_demux_pkg;

    // One address window: requests with start_addr <= add < end_addr go to tgt.
    typedef struct packed {
        logic [31:0] tgt;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_rule_t;

    // Result of testing one address against one rule.
    typedef struct packed {
        logic        match;
        logic [31:0] tgt;
    } rule_hit_t;

    // Read data returned by the internal error responder.
    localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;

    // Test a single rule; the end address is exclusive.
    function automatic rule_hit_t decode_rule(input addr_rule_t rule, input logic [31:0] addr);
        rule_hit_t hit;
        hit.match = (addr >= rule.start_addr) && (addr < rule.end_addr);
        hit.tgt   = rule.tgt;
        return hit;
    endfunction

endpackage

// File: rtl/fc_tcdm_addr_decode.sv
// Priority address decoder: maps an address to a target index, the lowest
// matching rule index wins. Index NB_TARGET is the internal error pseudo-target.
module fc_tcdm_addr_decode
    import fc_tcdm_demux_pkg::*;
#(
    parameter int                          NB_TARGET   = 2,
    parameter int                          NB_RULES    = 4,
    parameter addr_rule_t [NB_RULES-1:0]   RULES       = '0,
    parameter int                          DEFAULT_TGT = 0,
    parameter bit                          ERR_ON_MISS = 1'b0,
    parameter int                          SEL_W       = $clog2(NB_TARGET + 1)
) (
    input  logic [31:0]      i_add,
    output logic [SEL_W-1:0] o_sel
);

    localparam logic [31:0] MISS_TGT = ERR_ON_MISS ? 32'(NB_TARGET) : 32'(DEFAULT_TGT);

    rule_hit_t   w_hit;
    logic [31:0] w_tgt;

    // Scan rules from the highest index down so the lowest matching index is applied last.
    always_comb begin
        w_hit = '0;
        w_tgt = MISS_TGT;
        for (int i = NB_RULES - 1; i >= 0; i--) begin
            w_hit = decode_rule(RULES[i], i_add);
            w_tgt = w_hit.match ? w_hit.tgt : w_tgt;
        end
    end

    // Narrow the rule target to a port index; a target outside the port range lands on the error responder.
    always_comb begin
        o_sel = SEL_W'(NB_TARGET);
        for (int t = 0; t <= NB_TARGET; t++) begin
            o_sel = (w_tgt == 32'(t)) ? SEL_W'(t) : o_sel;
        end
    end

endmodule

// File: rtl/fc_tcdm_addr_demux_chk.sv
// Simulation checker: no target may return a response the demux is not waiting for.
module fc_tcdm_addr_demux_chk #(
    parameter int NB_TARGET = 2,
    parameter int SEL_W     = $clog2(NB_TARGET + 1)
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    input logic                 i_busy,
    input logic [SEL_W-1:0]     i_lock_tgt,
    input logic [NB_TARGET-1:0] i_r_valid
);

    logic w_spurious;

    // A response is spurious when nothing is outstanding or it comes from a port other than the locked one.
    always_comb begin
        w_spurious = 1'b0;
        for (int t = 0; t < NB_TARGET; t++) begin
            w_spurious = w_spurious | (i_r_valid[t] & (~i_busy | (i_lock_tgt != SEL_W'(t))));
        end
    end

    a_no_spurious_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni) !w_spurious)
        else $error("fc_tcdm_addr_demux: spurious m_r_valid_i");

endmodule

// File: rtl/fc_tcdm_addr_demux.sv
// Rule-based TCDM demux from the fabric-controller port to NB_TARGET masters,
// with multiple outstanding transactions kept in order by a target lock and an
// optional internal error responder for unmapped addresses.
module fc_tcdm_addr_demux
    import fc_tcdm_demux_pkg::*;
#(
    parameter int                        NB_TARGET       = 2,
    parameter int                        NB_RULES        = 4,
    parameter addr_rule_t [NB_RULES-1:0] RULES           = '0,
    parameter int                        DEFAULT_TGT     = 0,
    parameter bit                        ERR_ON_MISS     = 1'b0,
    parameter int                        MAX_OUTSTANDING = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        s_req_i,
    input  logic [31:0]                 s_add_i,
    input  logic                        s_wen_i,
    input  logic [31:0]                 s_wdata_i,
    input  logic [3:0]                  s_be_i,
    output logic                        s_gnt_o,
    output logic                        s_r_valid_o,
    output logic [31:0]                 s_r_rdata_o,
    output logic                        s_r_opc_o,
    output logic [NB_TARGET-1:0]        m_req_o,
    output logic [NB_TARGET-1:0][31:0]  m_add_o,
    output logic [NB_TARGET-1:0][31:0]  m_wdata_o,
    output logic [NB_TARGET-1:0]        m_wen_o,
    output logic [NB_TARGET-1:0][3:0]   m_be_o,
    input  logic [NB_TARGET-1:0]        m_gnt_i,
    input  logic [NB_TARGET-1:0]        m_r_valid_i,
    input  logic [NB_TARGET-1:0]        m_r_opc_i,
    input  logic [NB_TARGET-1:0][31:0]  m_r_rdata_i
);

    localparam int                SEL_W   = $clog2(NB_TARGET + 1);
    localparam int                CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [SEL_W-1:0]  ERR_SEL = SEL_W'(NB_TARGET);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]  ONE_CNT = CNT_W'(1);

    logic [SEL_W-1:0] w_sel;
    logic             w_sel_err;
    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_lock_tgt;
    logic             r_err_pend;
    logic             w_busy;
    logic             w_rsp_valid;
    logic [31:0]      w_rsp_rdata;
    logic             w_rsp_opc;
    logic             w_retire;
    logic             w_tgt_ok;
    logic             w_room;
    logic             w_fwd;
    logic             w_gnt;

    fc_tcdm_addr_decode #(
        .NB_TARGET   (NB_TARGET),
        .NB_RULES    (NB_RULES),
        .RULES       (RULES),
        .DEFAULT_TGT (DEFAULT_TGT),
        .ERR_ON_MISS (ERR_ON_MISS),
        .SEL_W       (SEL_W)
    ) u_decode (
        .i_add (s_add_i),
        .o_sel (w_sel)
    );

    fc_tcdm_addr_demux_chk #(
        .NB_TARGET (NB_TARGET),
        .SEL_W     (SEL_W)
    ) u_chk (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_busy     (w_busy),
        .i_lock_tgt (r_lock_tgt),
        .i_r_valid  (m_r_valid_i)
    );

    assign w_sel_err = (w_sel == ERR_SEL);
    assign w_busy    = (r_cnt != '0);

    // Address, write data, wen and byte enables go to every target; only m_req_o is steered.
    assign m_add_o   = {NB_TARGET{s_add_i}};
    assign m_wdata_o = {NB_TARGET{s_wdata_i}};
    assign m_wen_o   = {NB_TARGET{s_wen_i}};
    assign m_be_o    = {NB_TARGET{s_be_i}};

    // Pick the response of the locked target, or the error responder when locked to it.
    always_comb begin
        w_rsp_valid = 1'b0;
        w_rsp_rdata = 32'h0000_0000;
        w_rsp_opc   = 1'b0;
        if (r_lock_tgt == ERR_SEL) begin
            w_rsp_valid = r_err_pend;
            w_rsp_rdata = ERR_RDATA;
            w_rsp_opc   = 1'b1;
        end else begin
            for (int t = 0; t < NB_TARGET; t++) begin
                w_rsp_valid = (r_lock_tgt == SEL_W'(t)) ? m_r_valid_i[t] : w_rsp_valid;
                w_rsp_rdata = (r_lock_tgt == SEL_W'(t)) ? m_r_rdata_i[t] : w_rsp_rdata;
                w_rsp_opc   = (r_lock_tgt == SEL_W'(t)) ? m_r_opc_i[t]   : w_rsp_opc;
            end
        end
    end

    // With nothing outstanding the response side is idle, so late target responses are dropped.
    assign s_r_valid_o = w_busy & w_rsp_valid;
    assign s_r_rdata_o = w_busy ? w_rsp_rdata : 32'h0000_0000;
    assign s_r_opc_o   = w_busy & w_rsp_opc;
    assign w_retire    = s_r_valid_o;

    // A switch of target is allowed once the last outstanding response retires, even in that same cycle.
    assign w_tgt_ok = ~w_busy | (w_sel == r_lock_tgt) | ((r_cnt == ONE_CNT) & w_retire);
    assign w_room   = (r_cnt < MAX_CNT) | w_retire;
    assign w_fwd    = s_req_i & w_tgt_ok & w_room;

    // Steer the request to the selected target and return its grant; the error responder grants at once.
    always_comb begin
        m_req_o = '0;
        w_gnt   = w_fwd & w_sel_err;
        for (int t = 0; t < NB_TARGET; t++) begin
            m_req_o[t] = w_fwd & (w_sel == SEL_W'(t));
            w_gnt      = w_gnt | (w_fwd & (w_sel == SEL_W'(t)) & m_gnt_i[t]);
        end
    end

    assign s_gnt_o = w_gnt;

    // Track outstanding transactions, the target they belong to and the pending error response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt      <= '0;
            r_lock_tgt <= '0;
            r_err_pend <= 1'b0;
        end else begin
            if (w_gnt && !w_retire) begin
                r_cnt <= r_cnt + ONE_CNT;
            end else if (!w_gnt && w_retire) begin
                r_cnt <= r_cnt - ONE_CNT;
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_gnt) begin
                r_lock_tgt <= w_sel;
            end else begin
                r_lock_tgt <= r_lock_tgt;
            end
            if (w_gnt && w_sel_err) begin
                r_err_pend <= 1'b1;
            end else if (w_retire && (r_lock_tgt == ERR_SEL)) begin
                r_err_pend <= 1'b0;
            end else begin
                r_err_pend <= r_err_pend;
            end
        end
    end

endmodule
